// File: rtl/ecc_job_scheduler.sv
// Arbitrates two job requesters onto one ECC block: programs it over APB,
// waits (bounded) for completion and returns the result as a response.
module ecc_job_scheduler #(
   parameter int unsigned AMBA_ADDR_WIDTH = 20,
   parameter int unsigned AMBA_WORD       = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned TIMEOUT         = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req0_valid,
   output logic                       req0_ready,
   input  logic [1:0]                 req0_ctrl,
   input  logic [1:0]                 req0_width,
   input  logic [AMBA_WORD-1:0]       req0_data,
   input  logic [AMBA_WORD-1:0]       req0_noise,
   input  logic                       req1_valid,
   output logic                       req1_ready,
   input  logic [1:0]                 req1_ctrl,
   input  logic [1:0]                 req1_width,
   input  logic [AMBA_WORD-1:0]       req1_data,
   input  logic [AMBA_WORD-1:0]       req1_noise,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   input  logic                       operation_done,
   input  logic [DATA_WIDTH-1:0]      data_out,
   input  logic [1:0]                 num_of_errors,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic                       resp_id,
   output logic [DATA_WIDTH-1:0]      resp_data,
   output logic [1:0]                 resp_errors,
   output logic                       resp_timeout
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      W_WIDTH = 2'd0,
      W_DATA  = 2'd1,
      W_NOISE = 2'd2,
      W_CTRL  = 2'd3
   } widx_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t                  state_q, state_d;
   widx_t                   widx_q, widx_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    last_q, last_d;
   logic                    id_q, id_d;
   logic [1:0]              ctrl_q, ctrl_d;
   logic [1:0]              width_q, width_d;
   logic [AMBA_WORD-1:0]    data_q, data_d;
   logic [AMBA_WORD-1:0]    noise_q, noise_d;
   logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
   logic [1:0]              resp_errors_q, resp_errors_d;
   logic                    resp_timeout_q, resp_timeout_d;

   logic                       any_valid;
   logic                       grant_id;
   logic [AMBA_ADDR_WIDTH-1:0] sel_addr;
   logic [AMBA_WORD-1:0]       sel_wdata;

   // Requester 1 wins only when alone or when requester 0 had the last grant.
   assign any_valid = req0_valid | req1_valid;
   assign grant_id  = req1_valid & (~req0_valid | ~last_q);

   // Gated by rst so the handshake stays silent while reset is held.
   assign req0_ready = rst & (state_q == IDLE) & any_valid & ~grant_id;
   assign req1_ready = rst & (state_q == IDLE) & any_valid &  grant_id;

   assign resp_valid   = (state_q == RESP);
   assign resp_id      = id_q;
   assign resp_data    = resp_data_q;
   assign resp_errors  = resp_errors_q;
   assign resp_timeout = resp_timeout_q;

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      case (widx_q)
         W_WIDTH: begin
            sel_addr  = AMBA_ADDR_WIDTH'(8'h08);
            sel_wdata = AMBA_WORD'(width_q);
         end
         W_DATA: begin
            sel_addr  = AMBA_ADDR_WIDTH'(8'h04);
            sel_wdata = data_q;
         end
         W_NOISE: begin
            sel_addr  = AMBA_ADDR_WIDTH'(8'h0C);
            sel_wdata = noise_q;
         end
         default: begin
            sel_addr  = '0;
            sel_wdata = AMBA_WORD'(ctrl_q);
         end
      endcase
   end

   always_comb begin
      state_d        = state_q;
      widx_d         = widx_q;
      cnt_d          = cnt_q;
      last_d         = last_q;
      id_d           = id_q;
      ctrl_d         = ctrl_q;
      width_d        = width_q;
      data_d         = data_q;
      noise_d        = noise_q;
      resp_data_d    = resp_data_q;
      resp_errors_d  = resp_errors_q;
      resp_timeout_d = resp_timeout_q;
      PADDR          = '0;
      PWDATA         = '0;
      PSEL           = 1'b0;
      PENABLE        = 1'b0;
      PWRITE         = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_valid) begin
               state_d = SETUP;
               widx_d  = W_WIDTH;
               last_d  = grant_id;
               id_d    = grant_id;
               ctrl_d  = grant_id ? req1_ctrl  : req0_ctrl;
               width_d = grant_id ? req1_width : req0_width;
               data_d  = grant_id ? req1_data  : req0_data;
               noise_d = grant_id ? req1_noise : req0_noise;
            end
         end
         SETUP: begin
            PSEL    = 1'b1;
            PWRITE  = 1'b1;
            PADDR   = sel_addr;
            PWDATA  = sel_wdata;
            state_d = ACCESS;
         end
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            PWRITE  = 1'b1;
            PADDR   = sel_addr;
            PWDATA  = sel_wdata;
            if (widx_q == W_CTRL) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else begin
               state_d = SETUP;
               // Encode/decode jobs carry no noise word.
               if (widx_q == W_DATA && !ctrl_q[1])
                  widx_d = W_CTRL;
               else
                  widx_d = widx_t'(widx_q + 2'd1);
            end
         end
         WAIT: begin
            if (operation_done) begin
               resp_data_d    = data_out;
               resp_errors_d  = num_of_errors;
               resp_timeout_d = 1'b0;
               state_d        = RESP;
            end else if (cnt_q == CNT_LAST) begin
               resp_data_d    = '0;
               resp_errors_d  = '0;
               resp_timeout_d = 1'b1;
               state_d        = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            if (resp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         widx_q         <= W_WIDTH;
         cnt_q          <= '0;
         last_q         <= 1'b1;
         id_q           <= 1'b0;
         ctrl_q         <= '0;
         width_q        <= '0;
         data_q         <= '0;
         noise_q        <= '0;
         resp_data_q    <= '0;
         resp_errors_q  <= '0;
         resp_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         widx_q         <= widx_d;
         cnt_q          <= cnt_d;
         last_q         <= last_d;
         id_q           <= id_d;
         ctrl_q         <= ctrl_d;
         width_q        <= width_d;
         data_q         <= data_d;
         noise_q        <= noise_d;
         resp_data_q    <= resp_data_d;
         resp_errors_q  <= resp_errors_d;
         resp_timeout_q <= resp_timeout_d;
      end
   end

endmodule

// File: tb/tb_ecc_job_scheduler.sv
// Directed bench for ecc_job_scheduler: APB write sequences, arbitration,
// completion/timeout responses, response back-pressure and mid-transfer reset.
module tb_ecc_job_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [1:0]  req0_ctrl = '0, req1_ctrl = '0, req0_width = '0, req1_width = '0;
   logic [31:0] req0_data = '0, req1_data = '0, req0_noise = '0, req1_noise = '0;
   logic [19:0] PADDR;
   logic [31:0] PWDATA;
   logic        PSEL, PENABLE, PWRITE;
   logic        operation_done = 1'b0;
   logic [31:0] data_out = '0;
   logic [1:0]  num_of_errors = '0;
   logic        resp_valid, resp_ready = 1'b0, resp_id, resp_timeout;
   logic [31:0] resp_data;
   logic [1:0]  resp_errors;

   int tests_run = 0;
   int tests_failed = 0;

   logic [19:0] wa [8];
   logic [31:0] wd [8];
   int          wn, wcyc, wviol;

   ecc_job_scheduler #(
      .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .DATA_WIDTH(32), .TIMEOUT(15)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
      .req0_width(req0_width), .req0_data(req0_data), .req0_noise(req0_noise),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
      .req1_width(req1_width), .req1_data(req1_data), .req1_noise(req1_noise),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .resp_errors(resp_errors), .resp_timeout(resp_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int id, input logic [1:0] ctrl, input logic [1:0] width,
                            input logic [31:0] data, input logic [31:0] noise);
      if (id == 0) begin
         req0_valid = 1'b1; req0_ctrl = ctrl; req0_width = width;
         req0_data = data; req0_noise = noise;
      end else begin
         req1_valid = 1'b1; req1_ctrl = ctrl; req1_width = width;
         req1_data = data; req1_noise = noise;
      end
   endtask

   // Records SETUP/ACCESS write pairs until PSEL drops; protocol slips go to wviol.
   task automatic collect_writes;
      logic [19:0] sa;
      logic [31:0] sd;
      wn = 0; wcyc = 0; wviol = 0;
      for (int k = 0; k < 20 && PSEL === 1'b1; k++) begin
         if (PENABLE !== 1'b0 || PWRITE !== 1'b1) wviol++;
         sa = PADDR; sd = PWDATA;
         tick; wcyc++;
         if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PWRITE !== 1'b1 || PADDR !== sa || PWDATA !== sd)
            wviol++;
         if (wn < 8) begin wa[wn] = sa; wd[wn] = sd; end
         wn++;
         tick; wcyc++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      req0_valid = 1'b1;
      tick; tick;
      tests_run++; if (req0_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready0: got %b expected 0", req0_ready); end
      tests_run++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin tests_failed++; $display("FAIL rst_apb: got %b expected 000", {PSEL, PENABLE, PWRITE}); end
      tests_run++; if (PADDR !== 20'h0) begin tests_failed++; $display("FAIL rst_paddr: got %h expected 0", PADDR); end
      tests_run++; if ({resp_valid, resp_id, resp_timeout, resp_errors} !== 5'b0) begin tests_failed++; $display("FAIL rst_resp: got %b expected 00000", {resp_valid, resp_id, resp_timeout, resp_errors}); end
      tests_run++; if (resp_data !== 32'h0) begin tests_failed++; $display("FAIL rst_resp_data: got %h expected 0", resp_data); end
      req0_valid = 1'b0;
      rst = 1'b1;
      tick;
   endtask

   task automatic test_encode;
      drive_req(0, 2'b00, 2'b00, 32'h5, 32'hAA);
      #1;
      tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin tests_failed++; $display("FAIL enc_grant: got %b expected 10", {req0_ready, req1_ready}); end
      tick;
      req0_valid = 1'b0;
      collect_writes;
      tests_run++; if (wn !== 3 || wcyc !== 6 || wviol !== 0) begin tests_failed++; $display("FAIL enc_shape: got writes=%0d cycles=%0d viol=%0d expected 3 6 0", wn, wcyc, wviol); end
      tests_run++; if ({wa[0], wa[1], wa[2]} !== {20'h8, 20'h4, 20'h0}) begin tests_failed++; $display("FAIL enc_addr: got %h %h %h expected 8 4 0", wa[0], wa[1], wa[2]); end
      tests_run++; if ({wd[0], wd[1], wd[2]} !== {32'h0, 32'h5, 32'h0}) begin tests_failed++; $display("FAIL enc_wdata: got %h %h %h expected 0 5 0", wd[0], wd[1], wd[2]); end
      tests_run++; if (PADDR !== 20'h0 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL enc_wait_idle_bus: got paddr=%h rv=%b expected 0 0", PADDR, resp_valid); end
      operation_done = 1'b1; data_out = 32'h2D; num_of_errors = 2'b00;
      tick;
      operation_done = 1'b0;
      tests_run++; if ({resp_valid, resp_id, resp_timeout} !== 3'b100) begin tests_failed++; $display("FAIL enc_resp_flags: got %b expected 100", {resp_valid, resp_id, resp_timeout}); end
      tests_run++; if (resp_data !== 32'h2D || resp_errors !== 2'b00) begin tests_failed++; $display("FAIL enc_resp_data: got %h/%b expected 2d/00", resp_data, resp_errors); end
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL enc_resp_drop: got %b expected 0", resp_valid); end
   endtask

   task automatic test_full_channel;
      drive_req(1, 2'b10, 2'b01, 32'h1234, 32'h1);
      #1;
      tests_run++; if ({req0_ready, req1_ready} !== 2'b01) begin tests_failed++; $display("FAIL full_grant: got %b expected 01", {req0_ready, req1_ready}); end
      tick;
      req1_valid = 1'b0; req1_data = 32'hDEAD; req1_ctrl = 2'b00; req1_noise = 32'h7;
      collect_writes;
      tests_run++; if (wn !== 4 || wcyc !== 8 || wviol !== 0) begin tests_failed++; $display("FAIL full_shape: got writes=%0d cycles=%0d viol=%0d expected 4 8 0", wn, wcyc, wviol); end
      tests_run++; if ({wa[0], wa[1], wa[2], wa[3]} !== {20'h8, 20'h4, 20'hC, 20'h0}) begin tests_failed++; $display("FAIL full_addr: got %h %h %h %h expected 8 4 c 0", wa[0], wa[1], wa[2], wa[3]); end
      tests_run++; if ({wd[0], wd[1], wd[2], wd[3]} !== {32'h1, 32'h1234, 32'h1, 32'h2}) begin tests_failed++; $display("FAIL full_wdata: got %h %h %h %h expected 1 1234 1 2", wd[0], wd[1], wd[2], wd[3]); end
      tick; tick; tick;
      tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL full_early_resp: got %b expected 0", resp_valid); end
      operation_done = 1'b1; data_out = 32'hBEEF; num_of_errors = 2'b01;
      tick;
      operation_done = 1'b0;
      tests_run++; if ({resp_valid, resp_id, resp_timeout, resp_errors} !== 5'b11001) begin tests_failed++; $display("FAIL full_resp_flags: got %b expected 11001", {resp_valid, resp_id, resp_timeout, resp_errors}); end
      tests_run++; if (resp_data !== 32'hBEEF) begin tests_failed++; $display("FAIL full_resp_data: got %h expected beef", resp_data); end
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
   endtask

   task automatic test_timeout;
      int i;
      drive_req(0, 2'b01, 2'b10, 32'h77, 32'h0);
      tick;
      req0_valid = 1'b0;
      data_out = 32'hFFFF_FFFF; num_of_errors = 2'b11;
      collect_writes;
      i = 0;
      while (resp_valid !== 1'b1 && i < 40) begin tick; i++; end
      tests_run++; if (i !== 15) begin tests_failed++; $display("FAIL to_wait_cycles: got %0d expected 15", i); end
      tests_run++; if ({resp_valid, resp_timeout, resp_errors, resp_id} !== 5'b11000) begin tests_failed++; $display("FAIL to_resp_flags: got %b expected 11000", {resp_valid, resp_timeout, resp_errors, resp_id}); end
      tests_run++; if (resp_data !== 32'h0) begin tests_failed++; $display("FAIL to_resp_data: got %h expected 0", resp_data); end
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
   endtask

   task automatic test_resp_hold;
      drive_req(0, 2'b00, 2'b01, 32'h3, 32'h0);
      tick;
      req0_valid = 1'b0;
      collect_writes;
      operation_done = 1'b1; data_out = 32'h77; num_of_errors = 2'b10;
      tick;
      operation_done = 1'b0;
      req0_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         operation_done = (k == 4);
         data_out = 32'h99; num_of_errors = 2'b01;
         #1;
         tests_run++;
         if (resp_valid !== 1'b1 || resp_data !== 32'h77 || resp_errors !== 2'b10 || resp_timeout !== 1'b0 || req0_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_cycle%0d: got rv=%b data=%h err=%b to=%b rdy=%b expected 1 77 10 0 0", k, resp_valid, resp_data, resp_errors, resp_timeout, req0_ready);
         end
         tick;
      end
      operation_done = 1'b0;
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      tests_run++; if ({resp_valid, req0_ready} !== 2'b01) begin tests_failed++; $display("FAIL hold_regrant: got rv/rdy=%b expected 01", {resp_valid, req0_ready}); end
      req0_valid = 1'b0;
      #1;
      tests_run++; if (req0_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_withdraw: got %b expected 0", req0_ready); end
      tick;
      tests_run++; if (PSEL !== 1'b0) begin tests_failed++; $display("FAIL hold_stay_idle: got psel=%b expected 0", PSEL); end
   endtask

   task automatic test_back_to_back;
      logic exp_id;
      rst = 1'b0;
      tick;
      drive_req(0, 2'b00, 2'b00, 32'h11, 32'h0);
      drive_req(1, 2'b00, 2'b00, 32'h22, 32'h0);
      rst = 1'b1;
      for (int j = 0; j < 3; j++) begin
         exp_id = (j == 1);
         #1;
         tests_run++; if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin tests_failed++; $display("FAIL b2b_grant%0d: got %b expected %b", j, {req0_ready, req1_ready}, {~exp_id, exp_id}); end
         tick;
         collect_writes;
         tests_run++; if (wd[1] !== (exp_id ? 32'h22 : 32'h11)) begin tests_failed++; $display("FAIL b2b_data%0d: got %h expected %h", j, wd[1], exp_id ? 32'h22 : 32'h11); end
         operation_done = 1'b1; data_out = 32'(j); num_of_errors = 2'b00;
         tick;
         operation_done = 1'b0;
         tests_run++; if ({resp_valid, resp_id, req0_ready, req1_ready} !== {1'b1, exp_id, 2'b00}) begin tests_failed++; $display("FAIL b2b_resp%0d: got %b expected %b", j, {resp_valid, resp_id, req0_ready, req1_ready}, {1'b1, exp_id, 2'b00}); end
         resp_ready = 1'b1;
         tick;
         resp_ready = 1'b0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid_apb;
      drive_req(0, 2'b11, 2'b10, 32'hABCD, 32'h3);
      tick; tick; tick; tick;
      tests_run++; if ({PSEL, PENABLE, PADDR} !== {2'b11, 20'h4}) begin tests_failed++; $display("FAIL mid_pre: got sel/en=%b addr=%h expected 11 4", {PSEL, PENABLE}, PADDR); end
      rst = 1'b0;
      #1;
      tests_run++; if ({PSEL, PENABLE, PWRITE, req0_ready} !== 4'b0000 || PADDR !== 20'h0) begin tests_failed++; $display("FAIL mid_rst_now: got %b addr=%h expected 0000 0", {PSEL, PENABLE, PWRITE, req0_ready}, PADDR); end
      tick;
      rst = 1'b1;
      #1;
      tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_regrant: got %b expected 1", req0_ready); end
      tick;
      req0_valid = 1'b0;
      collect_writes;
      tests_run++; if (wn !== 4 || wcyc !== 8 || wviol !== 0) begin tests_failed++; $display("FAIL mid_shape: got writes=%0d cycles=%0d viol=%0d expected 4 8 0", wn, wcyc, wviol); end
      tests_run++; if ({wa[0], wd[0], wa[3], wd[3]} !== {20'h8, 32'h2, 20'h0, 32'h3}) begin tests_failed++; $display("FAIL mid_seq: got %h/%h .. %h/%h expected 8/2 .. 0/3", wa[0], wd[0], wa[3], wd[3]); end
      operation_done = 1'b1; data_out = 32'h5A; num_of_errors = 2'b10;
      tick;
      operation_done = 1'b0;
      tests_run++; if ({resp_valid, resp_id, resp_errors} !== 4'b1010 || resp_data !== 32'h5A) begin tests_failed++; $display("FAIL mid_resp: got %b data=%h expected 1010 5a", {resp_valid, resp_id, resp_errors}, resp_data); end
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
   endtask

   initial begin
      test_reset;
      test_encode;
      test_full_channel;
      test_timeout;
      test_resp_hold;
      test_back_to_back;
      test_reset_mid_apb;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
